// File: rtl/display_pkg.sv
// Shared display definitions: VGA 640x480@60 timing, pixel formats and colour expansion.
package display_pkg;

    localparam int CNT_W        = 10;

    localparam int VGA_H_VIS    = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_VIS    = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
    } rgb888_t;

    // Per-pixel control bits carried alongside the memory fetch.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic visible;
        logic in_win;
    } pix_ctl_t;

    // Replicate the top bits into the low bits so full-scale 565 maps to 0xFF.
    function automatic rgb888_t rgb565_to_rgb888(input rgb565_t c);
        rgb888_t o;
        o.r8 = {c.r5, c.r5[4:2]};
        o.g8 = {c.g6, c.g6[5:4]};
        o.b8 = {c.b5, c.b5[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate tick from a divide-by-two phase flop, h/v raster counters and raw sync/visible flags.
module vga_timing_gen
    import display_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic             pixel_phase,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync_raw_n,
    output logic             vsync_raw_n,
    output logic             visible,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_phase <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
        end else begin
            pixel_phase <= ~pixel_phase;
            if (pixel_phase) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign tick        = pixel_phase;
    assign hsync_raw_n = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vsync_raw_n = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign visible     = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the image memory in raster order for a scaled, positioned window and drives the video DAC;
// sync/blank travel through the same two-tick pipeline as the fetched colour.
module vga_frame_reader
    import display_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int SCALE  = 2,
    parameter int X0     = 192,
    parameter int Y0     = 112,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_enable,
    input  logic [15:0]       mem_data,
    output logic              vga_clk,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    localparam int               SCALE_SH = $clog2(SCALE);
    localparam logic [CNT_W-1:0] WIN_X0   = CNT_W'(X0);
    localparam logic [CNT_W-1:0] WIN_X1   = CNT_W'(X0 + IMG_W * SCALE);
    localparam logic [CNT_W-1:0] WIN_Y0   = CNT_W'(Y0);
    localparam logic [CNT_W-1:0] WIN_Y1   = CNT_W'(Y0 + IMG_H * SCALE);

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hsync_raw_n;
    logic             vsync_raw_n;
    logic             visible;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .pixel_phase (vga_clk),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync_raw_n (hsync_raw_n),
        .vsync_raw_n (vsync_raw_n),
        .visible     (visible),
        .frame_start (frame_start)
    );

    logic             in_win;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [ADDR_W-1:0] addr_calc;

    assign in_win    = (h_cnt >= WIN_X0) && (h_cnt < WIN_X1) &&
                       (v_cnt >= WIN_Y0) && (v_cnt < WIN_Y1);
    assign dx        = h_cnt - WIN_X0;
    assign dy        = v_cnt - WIN_Y0;
    assign col       = dx >> SCALE_SH;
    assign row       = dy >> SCALE_SH;
    assign addr_calc = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);

    pix_ctl_t s1_ctl;

    // Stage 1: issue the read; the strobe lasts one clk, the address is held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address     <= '0;
            mem_read_enable <= 1'b0;
            s1_ctl          <= '{hsync_n: 1'b1, vsync_n: 1'b1, visible: 1'b0, in_win: 1'b0};
        end else begin
            mem_read_enable <= 1'b0;
            if (tick) begin
                mem_read_enable <= in_win;
                if (in_win) begin
                    mem_address <= addr_calc;
                end
                s1_ctl <= '{hsync_n: hsync_raw_n, vsync_n: vsync_raw_n,
                            visible: visible, in_win: in_win};
            end
        end
    end

    rgb888_t pix_rgb;
    assign pix_rgb = rgb565_to_rgb888(rgb565_t'(mem_data));

    // Stage 2: memory answered on the clk between ticks, so mem_data is valid here.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (tick) begin
            vga_hsync   <= s1_ctl.hsync_n;
            vga_vsync   <= s1_ctl.vsync_n;
            vga_blank_n <= s1_ctl.visible;
            if (s1_ctl.in_win) begin
                vga_r <= pix_rgb.r8;
                vga_g <= pix_rgb.g8;
                vga_b <= pix_rgb.b8;
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench: full-size timing instance (A) plus a vertically shortened instance (B) sharing clock/reset,
// both compared against an arithmetic raster model with a behavioural 1-clk image memory.
module tb_vga_frame_reader;

    localparam int HT    = 800;
    localparam int XW0   = 192;
    localparam int A_VT  = 525;
    localparam int B_VV  = 20;
    localparam int B_VFP = 2;
    localparam int B_VSY = 2;
    localparam int B_VT  = 26;
    localparam int B_Y0  = 2;
    localparam int B_IH  = 8;

    logic clk;
    logic rst;

    logic [13:0] addr_a, addr_b;
    logic        re_a, re_b;
    logic [15:0] data_a, data_b;
    logic        vclk_a, vclk_b, hs_a, hs_b, vs_a, vs_b, bl_a, bl_b, sn_a, sn_b, fs_a, fs_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [15:0] mem [0:16383];

    int checks   = 0;
    int failures = 0;

    vga_frame_reader dut_a (
        .clk(clk), .rst(rst), .mem_address(addr_a), .mem_read_enable(re_a), .mem_data(data_a),
        .vga_clk(vclk_a), .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank_n(bl_a),
        .vga_sync_n(sn_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
    );

    vga_frame_reader #(
        .V_VIS(B_VV), .V_FP(B_VFP), .V_SYNC(B_VSY), .V_BP(2), .IMG_H(B_IH), .Y0(B_Y0)
    ) dut_b (
        .clk(clk), .rst(rst), .mem_address(addr_b), .mem_read_enable(re_b), .mem_data(data_b),
        .vga_clk(vclk_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank_n(bl_b),
        .vga_sync_n(sn_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        data_a = '0;
        data_b = '0;
    end

    always @(posedge clk) begin
        if (re_a) data_a <= mem[addr_a];
        if (re_b) data_b <= mem[addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit win_of(int p, int vt, int y0, int ih);
        int h, v;
        h = p % HT;
        v = (p / HT) % vt;
        return (h >= XW0) && (h < XW0 + 256) && (v >= y0) && (v < y0 + 2 * ih);
    endfunction

    function automatic int addr_of(int p, int vt, int y0);
        int h, v;
        h = p % HT;
        v = (p / HT) % vt;
        return (((v - y0) / 2) * 128 + (h - XW0) / 2) % 16384;
    endfunction

    function automatic int rgb_of(int w);
        int r5, g6, b5;
        r5 = (w / 2048) % 32;
        g6 = (w / 32) % 64;
        b5 = w % 32;
        return (((r5 * 8) + (r5 / 4)) * 65536) + (((g6 * 4) + (g6 / 16)) * 256) + ((b5 * 8) + (b5 / 4));
    endfunction

    typedef struct {
        int vclk; int fs; int re; int addr; int hs; int vs; int bl; int rgb;
    } exp_t;

    function automatic exp_t expect_out(int mm, int held, int vt, int vv, int vfp, int vsy,
                                        int y0, int ih);
        exp_t e;
        int n, q, h, v;
        e = '{0, 0, 0, 0, 1, 1, 0, 0};
        if (mm < 0) return e;
        if (mm % 2 == 0) begin
            n = mm / 2;
            e.vclk = 1;
            e.fs = (n % (HT * vt) == 0) ? 1 : 0;
            q = n - 2;
        end else begin
            n = (mm - 1) / 2;
            e.re = win_of(n, vt, y0, ih) ? 1 : 0;
            q = n - 1;
        end
        e.addr = held;
        if (q >= 0) begin
            h = q % HT;
            v = (q / HT) % vt;
            e.hs = (h >= 656 && h < 752) ? 0 : 1;
            e.vs = (v >= vv + vfp && v < vv + vfp + vsy) ? 0 : 1;
            e.bl = (h < 640 && v < vv) ? 1 : 0;
            e.rgb = win_of(q, vt, y0, ih) ? rgb_of(int'(mem[addr_of(q, vt, y0)])) : 0;
        end
        return e;
    endfunction

    // m = clk edges since reset release (-1 while in reset); held_* = last address issued.
    int m = -1;
    int held_a = 0;
    int held_b = 0;
    bit started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m <= -1;
            held_a <= 0;
            held_b <= 0;
            started <= 1'b1;
        end else if (started) begin
            m <= m + 1;
            if ((m + 1) % 2 == 1) begin
                if (win_of(m / 2, A_VT, 112, 128)) held_a <= addr_of(m / 2, A_VT, 112);
                if (win_of(m / 2, B_VT, B_Y0, B_IH)) held_b <= addr_of(m / 2, B_VT, B_Y0);
            end
        end
    end

    task automatic score_all();
        exp_t ea, eb;
        ea = expect_out(m, held_a, A_VT, 480, 10, 2, 112, 128);
        eb = expect_out(m, held_b, B_VT, B_VV, B_VFP, B_VSY, B_Y0, B_IH);
        chk("A.vga_clk", 32'(vclk_a), ea.vclk);
        chk("A.frame_start", 32'(fs_a), ea.fs);
        chk("A.read_enable", 32'(re_a), ea.re);
        chk("A.address", 32'(addr_a), ea.addr);
        chk("A.hsync", 32'(hs_a), ea.hs);
        chk("A.vsync", 32'(vs_a), ea.vs);
        chk("A.blank_n", 32'(bl_a), ea.bl);
        chk("A.rgb", 32'({r_a, g_a, b_a}), ea.rgb);
        chk("B.vga_clk", 32'(vclk_b), eb.vclk);
        chk("B.frame_start", 32'(fs_b), eb.fs);
        chk("B.read_enable", 32'(re_b), eb.re);
        chk("B.address", 32'(addr_b), eb.addr);
        chk("B.hsync", 32'(hs_b), eb.hs);
        chk("B.vsync", 32'(vs_b), eb.vs);
        chk("B.blank_n", 32'(bl_b), eb.bl);
        chk("B.rgb", 32'({r_b, g_b, b_b}), eb.rgb);
        chk("B.sync_n", 32'(sn_b), 0);
    endtask

    always @(negedge clk) begin
        if (started && $urandom_range(0, 15) == 0) score_all();
    end

    // ---------------- first-frame monitors ----------------
    int epoch = 0;
    int hs_low = 0, vs_low = 0;
    int hs_fall1 = -1, hs_fall2 = -1, fs2_b = -1;
    logic prev_hs_a = 1'b1;

    always @(negedge clk) begin
        if (started && epoch == 0 && m >= 0 && m % 2 == 0) begin
            if (m / 2 < HT && hs_a === 1'b0) hs_low <= hs_low + 1;
            if (m / 2 < HT * B_VT && vs_b === 1'b0) vs_low <= vs_low + 1;
            if (hs_a === 1'b0 && prev_hs_a === 1'b1) begin
                if (hs_fall1 < 0) hs_fall1 <= m / 2;
                else if (hs_fall2 < 0) hs_fall2 <= m / 2;
            end
            prev_hs_a <= hs_a;
            if (m > 0 && fs_b === 1'b1 && fs2_b < 0) fs2_b <= m / 2;
        end
    end

    task automatic wait_m(input int target);
        int guard;
        guard = 0;
        while (m < target && guard < 120000) begin
            @(negedge clk);
            guard++;
        end
        if (m < target) chk("wait_budget", 32'(m), 32'(target));
    endtask

    typedef struct {
        int x; int y; int re; int addr; int chk_rgb; int rgb; int bl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, y;
        rst = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom_range(0, 65535));
        mem[5] = 16'hF800;
        mem[6] = 16'h07E0;
        mem[7] = 16'h8410;

        tbl = '{
            '{192,  2, 1,    0, 0,        0, 1},
            '{193,  2, 1,    0, 0,        0, 1},
            '{194,  2, 1,    1, 0,        0, 1},
            '{202,  2, 1,    5, 1, 'hFF0000, 1},
            '{204,  2, 1,    6, 1, 'h00FF00, 1},
            '{206,  2, 1,    7, 1, 'h848284, 1},
            '{700,  3, 0,    0, 1,        0, 0},
            '{192,  4, 1,  128, 0,        0, 1},
            '{100, 10, 0,    0, 1,        0, 1},
            '{447, 17, 1, 1023, 0,        0, 1}
        };

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.hsync", 32'({hs_a, hs_b}), 2'b11);
        chk("rst.vsync", 32'({vs_a, vs_b}), 2'b11);
        chk("rst.blank_n", 32'({bl_a, bl_b}), 0);
        chk("rst.rgb", 32'({r_a, g_a, b_a} | {r_b, g_b, b_b}), 0);
        chk("rst.read_enable", 32'({re_a, re_b}), 0);
        chk("rst.address", 32'({addr_a, addr_b}), 0);
        chk("rst.frame_start", 32'({fs_a, fs_b}), 0);
        chk("rst.vga_clk", 32'({vclk_a, vclk_b}), 0);
        rst = 1'b0;

        @(negedge clk);
        chk("first_tick.frame_start", 32'({fs_a, fs_b}), 2'b11);
        chk("first_tick.vga_clk", 32'({vclk_a, vclk_b}), 2'b11);

        foreach (tbl[i]) begin
            n = tbl[i].y * HT + tbl[i].x;
            wait_m(2 * n + 1);
            chk($sformatf("tbl%0d.read_enable", i), 32'(re_b), tbl[i].re);
            if (tbl[i].re != 0) chk($sformatf("tbl%0d.address", i), 32'(addr_b), tbl[i].addr);
            wait_m(2 * n + 3);
            if (tbl[i].chk_rgb != 0) chk($sformatf("tbl%0d.rgb", i), 32'({r_b, g_b, b_b}), tbl[i].rgb);
            chk($sformatf("tbl%0d.blank_n", i), 32'(bl_b), tbl[i].bl);
        end

        wait_m(2 * HT * B_VT + 2);
        chk("hsync_low_ticks", 32'(hs_low), 96);
        chk("hsync_period", 32'(hs_fall2 - hs_fall1), HT);
        chk("vsync_low_ticks", 32'(vs_low), 2 * HT);
        chk("frame_period_b", 32'(fs2_b), HT * B_VT);

        epoch = 1;
        y = B_Y0 + $urandom_range(0, 2 * B_IH - 1);
        n = HT * B_VT + y * HT + 300;
        wait_m(2 * n);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.rgb", 32'({r_b, g_b, b_b}), 0);
        chk("midrst.read_enable", 32'({re_a, re_b}), 0);
        chk("midrst.hsync", 32'({hs_a, hs_b}), 2'b11);
        chk("midrst.blank_n", 32'({bl_a, bl_b}), 0);
        chk("midrst.address", 32'(addr_b), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.frame_start", 32'({fs_a, fs_b}), 2'b11);
        chk("midrst.rgb_t0", 32'({r_b, g_b, b_b}), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst.rgb_t%0d", k), 32'({r_b, g_b, b_b}), 0);
        end
        chk("midrst.second_tick_no_pulse", 32'({fs_a, fs_b}), 0);

        repeat (600) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
